// File: rtl/ram_arbiter.sv
// Backing-RAM controller that shares one fixed-latency word RAM between the data and instruction caches.
module ram_arbiter #(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 4,
  parameter     MEM_FILE  = "dat.hex"
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        readRAM,
  input  logic        writeRAM,
  input  logic [31:0] addressToRAM,
  input  logic [31:0] valueRAM,
  output logic        dataUsingRAM,
  input  logic        instRead,
  input  logic [31:0] instAddress,
  output logic        instUsingRAM,
  output logic        ramReady,
  output logic [31:0] outRAM
);

  // state | meaning
  // IDLE  | no grant; requests sampled, data port before instruction port
  // RD    | read latency countdown
  // WB    | write-back latency countdown; commit at terminal count
  // FILL  | read of the miss address after a write-back
  // DONE  | ramReady strobe; grant released on the next edge
  typedef enum logic [2:0] {IDLE, RD, WB, FILL, DONE} state_t;

  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  logic [31:0] mem [MEM_WORDS];

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   val_q, val_d;
  logic          dgnt_q, dgnt_d;
  logic          ignt_q, ignt_d;
  logic          rdy_q, rdy_d;
  logic [31:0]   out_q, out_d;
  logic          mem_we;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{addressToRAM[31:AW+2], addressToRAM[1:0],
                              instAddress[31:AW+2], instAddress[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    val_d   = val_q;
    dgnt_d  = dgnt_q;
    ignt_d  = ignt_q;
    rdy_d   = rdy_q;
    out_d   = out_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (writeRAM || readRAM) begin
          dgnt_d  = 1'b1;
          addr_d  = addressToRAM[AW+1:2];
          val_d   = valueRAM;
          cnt_d   = CNT_INIT;
          state_d = writeRAM ? WB : RD;
        end else if (instRead) begin
          ignt_d  = 1'b1;
          addr_d  = instAddress[AW+1:2];
          cnt_d   = CNT_INIT;
          state_d = RD;
        end
      end
      RD, FILL: begin
        if (cnt_q == '0) begin
          out_d   = mem[addr_q];
          rdy_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WB: begin
        if (cnt_q == '0) begin
          mem_we  = 1'b1;
          // the cache has switched the address bus to the miss address by now
          addr_d  = addressToRAM[AW+1:2];
          cnt_d   = CNT_INIT;
          state_d = FILL;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        dgnt_d  = 1'b0;
        ignt_d  = 1'b0;
        rdy_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      val_q   <= '0;
      dgnt_q  <= 1'b0;
      ignt_q  <= 1'b0;
      rdy_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      val_q   <= val_d;
      dgnt_q  <= dgnt_d;
      ignt_q  <= ignt_d;
      rdy_q   <= rdy_d;
      out_q   <= out_d;
    end
  end

  // array is never reset; mem_we is only high in WB, so a reset aborts the commit
  always_ff @(posedge clock) begin
    if (mem_we) mem[addr_q] <= val_q;
  end

  assign dataUsingRAM = dgnt_q;
  assign instUsingRAM = ignt_q;
  assign ramReady     = rdy_q;
  assign outRAM       = out_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a LATENCY=4 instance driven through a result scoreboard,
// plus a LATENCY=1 instance for back-to-back instruction fills.
module tb_ram_arbiter;
  localparam int LAT = 4;

  logic        clock;
  logic        reset;
  logic        readRAM, writeRAM, instRead;
  logic [31:0] addressToRAM, valueRAM, instAddress;
  logic        dataUsingRAM, instUsingRAM, ramReady;
  logic [31:0] outRAM;

  logic        rd1, wr1, ir1;
  logic [31:0] a1, v1, ia1;
  logic        du1, iu1, rr1;
  logic [31:0] o1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] word;
    bit          port;
  } exp_t;
  exp_t sb_q[$];

  ram_arbiter #(.MEM_WORDS(1024), .LATENCY(LAT)) u_dut (
    .clock(clock), .reset(reset),
    .readRAM(readRAM), .writeRAM(writeRAM),
    .addressToRAM(addressToRAM), .valueRAM(valueRAM),
    .dataUsingRAM(dataUsingRAM),
    .instRead(instRead), .instAddress(instAddress),
    .instUsingRAM(instUsingRAM),
    .ramReady(ramReady), .outRAM(outRAM)
  );

  ram_arbiter #(.MEM_WORDS(1024), .LATENCY(1)) u_dut_l1 (
    .clock(clock), .reset(reset),
    .readRAM(rd1), .writeRAM(wr1),
    .addressToRAM(a1), .valueRAM(v1),
    .dataUsingRAM(du1),
    .instRead(ir1), .instAddress(ia1),
    .instUsingRAM(iu1),
    .ramReady(rr1), .outRAM(o1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard: every result strobe pops one expectation
  always @(negedge clock) begin
    if (reset) begin
      chk("onehot_gnt", 32'(dataUsingRAM & instUsingRAM), 0);
      if (ramReady) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 32'(sb_q.size()), 1);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("sb_word", outRAM, e.word);
          chk("sb_port", 32'({dataUsingRAM, instUsingRAM}), e.port ? 32'd1 : 32'd2);
        end
      end
    end
  end

  task automatic data_op(input bit wr, input logic [31:0] addr, input logic [31:0] val,
                         input logic [31:0] fill_addr, input logic [31:0] exp_word);
    int n;
    @(posedge clock); #1;
    writeRAM = wr; readRAM = !wr; addressToRAM = addr; valueRAM = val;
    sb_q.push_back('{exp_word, 1'b0});
    n = 0;
    do begin @(posedge clock); #1; n++; end while (!dataUsingRAM && n < 40);
    chk("d_gnt_lat", n, 1);
    chk("d_gnt_excl", 32'(instUsingRAM), 0);
    writeRAM = 1'b0; readRAM = 1'b0; addressToRAM = fill_addr;
    n = 0;
    do begin @(posedge clock); #1; n++; end while (!ramReady && n < 40);
    chk("d_rdy_lat", n, wr ? 2 * LAT : LAT);
    @(posedge clock); #1;
    chk("d_gnt_drop", 32'(dataUsingRAM), 0);
    chk("d_rdy_1cyc", 32'(ramReady), 0);
    chk("d_out_hold", outRAM, exp_word);
  endtask

  task automatic inst_op(input logic [31:0] addr, input logic [31:0] exp_word);
    int n;
    @(posedge clock); #1;
    instRead = 1'b1; instAddress = addr;
    sb_q.push_back('{exp_word, 1'b1});
    n = 0;
    do begin @(posedge clock); #1; n++; end while (!instUsingRAM && n < 40);
    chk("i_gnt_lat", n, 1);
    instRead = 1'b0;
    n = 0;
    do begin @(posedge clock); #1; n++; end while (!ramReady && n < 40);
    chk("i_rdy_lat", n, LAT);
    @(posedge clock); #1;
    chk("i_gnt_drop", 32'(instUsingRAM), 0);
    chk("i_rdy_1cyc", 32'(ramReady), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [5:0] exp_iu;
    logic [5:0] exp_rr;
    reset = 1'b0;
    readRAM = 0; writeRAM = 0; instRead = 0;
    addressToRAM = 0; valueRAM = 0; instAddress = 0;
    rd1 = 0; wr1 = 0; ir1 = 0; a1 = 0; v1 = 0; ia1 = 0;
    #12;
    chk("rst_dgnt", 32'(dataUsingRAM), 0);
    chk("rst_ignt", 32'(instUsingRAM), 0);
    chk("rst_rdy", 32'(ramReady), 0);
    chk("rst_out", outRAM, 0);
    chk("rst_l1_out", o1, 0);
    @(negedge clock); reset = 1'b1;

    // preload by write-back then fill to the same word
    data_op(1, 32'h14, 32'hA1B2C3D4, 32'h14, 32'hA1B2C3D4);
    data_op(1, 32'h40, 32'h12345678, 32'h40, 32'h12345678);
    // plain reads; low and upper address bits ignored
    data_op(0, 32'h14, 0, 32'h0, 32'hA1B2C3D4);
    data_op(0, 32'h17, 0, 32'h0, 32'hA1B2C3D4);
    data_op(0, 32'hFFFF_F014, 0, 32'h0, 32'hA1B2C3D4);
    // write-back to 0x20, fill from 0x40
    data_op(1, 32'h20, 32'hDEADBEEF, 32'h40, 32'h12345678);
    data_op(0, 32'h20, 0, 32'h0, 32'hDEADBEEF);
    data_op(1, 32'h24, 32'hCAFEF00D, 32'h24, 32'hCAFEF00D);

    // simultaneous data and instruction requests
    @(posedge clock); #1;
    readRAM = 1'b1; addressToRAM = 32'h14;
    instRead = 1'b1; instAddress = 32'h24;
    sb_q.push_back('{32'hA1B2C3D4, 1'b0});
    sb_q.push_back('{32'hCAFEF00D, 1'b1});
    n = 0;
    do begin @(posedge clock); #1; n++; end while (!dataUsingRAM && n < 40);
    chk("sim_dgnt_lat", n, 1);
    chk("sim_ignt_wait", 32'(instUsingRAM), 0);
    readRAM = 1'b0;
    n = 0;
    do begin @(posedge clock); #1; n++; end while (!ramReady && n < 40);
    chk("sim_drdy_lat", n, LAT);
    @(posedge clock); #1;
    chk("sim_idle_rdy", 32'(ramReady), 0);
    chk("sim_idle_gnt", 32'({dataUsingRAM, instUsingRAM}), 0);
    n = 0;
    do begin @(posedge clock); #1; n++; end while (!instUsingRAM && n < 40);
    chk("sim_ignt_gap", n, 1);
    instRead = 1'b0;
    n = 0;
    do begin @(posedge clock); #1; n++; end while (!ramReady && n < 40);
    chk("sim_irdy_lat", n, LAT);
    @(posedge clock); #1;
    chk("sim_irdy_1cyc", 32'(ramReady), 0);
    chk("sim_ignt_drop", 32'(instUsingRAM), 0);

    // reset two cycles into a write-back must not commit it
    @(posedge clock); #1;
    writeRAM = 1'b1; addressToRAM = 32'h14; valueRAM = 32'h11111111;
    n = 0;
    do begin @(posedge clock); #1; n++; end while (!dataUsingRAM && n < 40);
    chk("rwb_gnt_lat", n, 1);
    writeRAM = 1'b0;
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
    #1;
    chk("rwb_dgnt", 32'(dataUsingRAM), 0);
    chk("rwb_rdy", 32'(ramReady), 0);
    chk("rwb_out", outRAM, 0);
    @(posedge clock); @(posedge clock);
    @(negedge clock); reset = 1'b1;
    data_op(0, 32'h14, 0, 32'h0, 32'hA1B2C3D4);
    inst_op(32'h24, 32'hCAFEF00D);
    inst_op(32'h20, 32'hDEADBEEF);

    // LATENCY=1 instance
    @(posedge clock); #1;
    wr1 = 1'b1; a1 = 32'h30; v1 = 32'h0BADF00D;
    n = 0;
    do begin @(posedge clock); #1; n++; end while (!du1 && n < 40);
    chk("l1_wgnt_lat", n, 1);
    wr1 = 1'b0;
    n = 0;
    do begin @(posedge clock); #1; n++; end while (!rr1 && n < 40);
    chk("l1_wrdy_lat", n, 2);
    chk("l1_fill_out", o1, 32'h0BADF00D);
    @(posedge clock); #1;
    chk("l1_wgnt_drop", 32'(du1), 0);
    @(posedge clock); #1;
    ir1 = 1'b1; ia1 = 32'h30;
    exp_iu = 6'b011011;
    exp_rr = 6'b010010;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      chk("l1_iu", 32'(iu1), 32'(exp_iu[i]));
      chk("l1_rr", 32'(rr1), 32'(exp_rr[i]));
      chk("l1_du", 32'(du1), 0);
      chk("l1_out", o1, 32'h0BADF00D);
    end
    ir1 = 1'b0;
    @(posedge clock); #1;
    chk("l1_quiet", 32'(iu1), 0);

    repeat (2) @(posedge clock);
    chk("sb_left", 32'(sb_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
